fetch_sequencer: RTL and testbench

Instruction-fetch controller sitting between the program counter logic and the word-addressed instruction memory. Owns PC/nPC, drives the memory address every cycle, captures returned words into a small prefetch queue, and hands {pc, instr} pairs to decode over a valid/ready handshake. Redirects from the branch/jump unit (bne, call, jmpl) flush the queue and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_queue.sv | 38 +++
 rtl/fetch_sequencer.sv | 54 +++++
 tb/tb_fetch_sequencer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch entry type, word-alignment shift and default reset PC
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam int WORD_SHIFT = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry sync FIFO (clk, rst, i_push/i_pop/i_flush, i_data in; o_head, o_count out)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      if (rst) r_mem <= '{default: '0};
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + AW'(1);
      end
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns pc, drives imem_addr, queues {pc,instr} for decode, handles redirects and counts accepted instructions
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] fetch_count
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] r_pc, r_fetch_count, w_target;
  logic [CW-1:0] w_count;
  logic w_pop, w_push, w_full;
  fetch_entry_t w_head, w_entry;
  assign w_full = w_count == CW'(DEPTH);
  assign out_valid = w_count != '0;
  assign w_pop = out_valid & out_ready;
  assign w_push = ~redir_valid & (~w_full | w_pop);
  assign w_target = redir_target & ~((32'd1 << WORD_SHIFT) - 32'd1);
  assign w_entry = '{pc: r_pc, instr: imem_instr};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pc <= redir_valid ? w_target : w_push ? r_pc + (32'd1 << WORD_SHIFT) : r_pc;
      r_fetch_count <= r_fetch_count + 32'(w_pop & ~redir_valid);
    end
  end
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redir_valid),
    .i_data (w_entry),
    .o_head (w_head),
    .o_count(w_count)
  );
  assign imem_addr = r_pc;
  assign out_pc = w_head.pc;
  assign out_instr = w_head.instr;
  assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed checks of fetch_sequencer against a queue-based reference model
module tb_fetch_sequencer;
  import fetch_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, rst, out_ready, redir_valid, out_valid;
  logic [31:0] redir_target, imem_addr, imem_instr, out_pc, out_instr, fetch_count;
  int n_cmp = 0, n_bad = 0;
  fetch_entry_t mq[$];
  logic [31:0] m_pc, m_fc;
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:  rom = 32'h8A00_0000;
      32'h4:  rom = 32'h86A0_E001;
      32'h8:  rom = 32'hC408_0001;
      32'h14: rom = 32'h0B0F_0F06;
      32'h18: rom = 32'h4000_0004;
      default: rom = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction
  assign imem_instr = rom(imem_addr);
  fetch_sequencer #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .redir_valid(redir_valid), .redir_target(redir_target), .fetch_count(fetch_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare_model();
    check("model_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("model_pc", out_pc, mq[0].pc);
      check("model_instr", out_instr, mq[0].instr);
    end
    check("model_addr", imem_addr, m_pc);
    check("model_count", fetch_count, m_fc);
  endtask
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt);
    bit pop, push;
    compare_model();
    rst = r; out_ready = rdy; redir_valid = rv; redir_target = tgt;
    if (r) begin
      mq.delete(); m_pc = 32'h0; m_fc = 0;
    end else if (rv) begin
      mq.delete(); m_pc = {tgt[31:2], 2'b00};
    end else begin
      pop = (mq.size() != 0) && rdy;
      push = (mq.size() < DEPTH) || pop;
      if (pop) begin
        void'(mq.pop_front());
        m_fc++;
      end
      if (push) begin
        mq.push_back('{pc: m_pc, instr: rom(m_pc)});
        m_pc += 4;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] fc0;
    rst = 1; out_ready = 0; redir_valid = 0; redir_target = 0;
    mq.delete(); m_pc = 0; m_fc = 0;
    @(negedge clk); @(negedge clk);
    step(1, 0, 0, 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_addr", imem_addr, 0);
    check("rst_count", fetch_count, 0);
    step(0, 1, 0, 0);
    check("h0_valid", 32'(out_valid), 1);
    check("h0_pc", out_pc, 32'h0);
    check("h0_instr", out_instr, 32'h8A00_0000);
    step(0, 1, 0, 0);
    check("h1_pc", out_pc, 32'h4);
    check("h1_instr", out_instr, 32'h86A0_E001);
    step(0, 1, 0, 0);
    check("h2_pc", out_pc, 32'h8);
    check("h2_instr", out_instr, 32'hC408_0001);
    step(0, 1, 0, 0);
    check("count3", fetch_count, 3);
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_pc", out_pc, 32'h0);
    step(0, 1, 0, 0);
    check("release_pc", out_pc, 32'h4);
    fc0 = fetch_count;
    step(0, 1, 1, 32'h14);
    check("redir_bubble", 32'(out_valid), 0);
    check("redir_count", fetch_count, fc0);
    step(0, 1, 0, 0);
    check("redir_valid", 32'(out_valid), 1);
    check("redir_pc", out_pc, 32'h14);
    check("redir_instr", out_instr, 32'h0B0F_0F06);
    step(0, 0, 1, 32'h1B);
    step(0, 0, 0, 0);
    check("mis_pc", out_pc, 32'h18);
    check("mis_instr", out_instr, 32'h4000_0004);
    step(1, 1, 1, 32'h40);
    check("rst_ovr_valid", 32'(out_valid), 0);
    check("rst_ovr_addr", imem_addr, 0);
    check("rst_ovr_count", fetch_count, 0);
    step(0, 1, 1, 32'hFFFF_FFFC);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    check("wrap_addr1", imem_addr, 32'h0);
    check("wrap_head", out_pc, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    check("wrap_addr2", imem_addr, 32'h4);
    check("wrap_head2", out_pc, 32'h0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(9) == 0, $urandom);
    compare_model();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
